// File: rtl/dispatch_scheduler_pkg.sv
// Shared types and constants for the dispatch scheduler: class encoding,
// RV32 opcode constants, FSM states and the slot classification helper.
package dispatch_scheduler_pkg;

  localparam int CW = 8;

  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] F7_MULDIV  = 7'b0000001;

  typedef enum logic [1:0] {
    CLS_ALU = 2'd0,
    CLS_MUL = 2'd1,
    CLS_MEM = 2'd2,
    CLS_BR  = 2'd3
  } dclass_e;

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_FLUSH  = 2'd1,
    ST_REFILL = 2'd2
  } sched_state_e;

  function automatic dclass_e classify(input logic [6:0] opc, input logic [6:0] f7);
    dclass_e c;
    c = CLS_ALU;
    case (opc)
      OPC_LOAD, OPC_STORE:           c = CLS_MEM;
      OPC_BRANCH, OPC_JAL, OPC_JALR: c = CLS_BR;
      OPC_OP:                        c = (f7 == F7_MULDIV) ? CLS_MUL : CLS_ALU;
      default:                       c = CLS_ALU;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/dispatch_scheduler_if.sv
// Bundle between the instruction queue / ROB / RS owners and the scheduler,
// plus debug visibility of FSM state and credit counters.
interface dispatch_scheduler_if
  import dispatch_scheduler_pkg::*;
#(
  parameter int SUPERSCALAR = 2,
  parameter int ROB_DEPTH   = 16
);
  // Handshake: instr_pop[i] is the ready for instr_valid_out[i]; slot i leaves
  // the queue in a cycle where both are high, and dispatch_class[i] is
  // meaningful only in that cycle (zero otherwise).
  logic [SUPERSCALAR-1:0]         instr_valid_out;
  logic [SUPERSCALAR-1:0][6:0]    opcode;
  logic [SUPERSCALAR-1:0][6:0]    funct7;
  logic [$clog2(ROB_DEPTH+1)-1:0] rob_release;
  logic [3:0][1:0]                rs_release;
  logic                           flush;
  logic [SUPERSCALAR-1:0]         instr_pop;
  logic [SUPERSCALAR-1:0][1:0]    dispatch_class;
  logic                           stall;
  sched_state_e                   dbg_state;
  logic [CW-1:0]                  dbg_rob_credit;
  logic [3:0][CW-1:0]             dbg_rs_credit;

  modport master (
    output instr_valid_out, opcode, funct7, rob_release, rs_release, flush,
    input  instr_pop, dispatch_class, stall, dbg_state, dbg_rob_credit, dbg_rs_credit
  );

  modport slave (
    input  instr_valid_out, opcode, funct7, rob_release, rs_release, flush,
    output instr_pop, dispatch_class, stall, dbg_state, dbg_rob_credit, dbg_rs_credit
  );
endinterface

// File: rtl/dispatch_scheduler_credit_counter.sv
// Saturating credit counter: next = count - take + give, reloaded to MAX on
// reset or while the scheduler is flushing.
module credit_counter
  import dispatch_scheduler_pkg::*;
#(
  parameter int MAX = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          reload,
  input  logic [CW-1:0] take,
  input  logic [CW-1:0] give,
  output logic [CW-1:0] count
);
  localparam logic [CW:0] MAX_W = MAX[CW:0];

  logic [CW-1:0] r_count;
  logic [CW:0]   w_sum;

  assign w_sum = {1'b0, r_count} + {1'b0, give} - {1'b0, take};

  always_ff @(posedge clk) begin
    if (!rst || reload) begin
      r_count <= MAX_W[CW-1:0];
    end else if (w_sum > MAX_W) begin
      r_count <= MAX_W[CW-1:0];
    end else begin
      r_count <= w_sum[CW-1:0];
    end
  end

  assign count = r_count;

  // Over-release means an owner returned credits it never took.
  a_release_overflow: assert property (@(posedge clk) disable iff (!rst || reload)
    w_sum <= MAX_W);
  a_take_underflow: assert property (@(posedge clk) disable iff (!rst || reload)
    take <= r_count);

endmodule

// File: rtl/dispatch_scheduler.sv
// In-order dispatch from the queue tail line into ROB and reservation
// stations, gated by cumulative per-slot credit checks and a flush FSM.
module dispatch_scheduler
  import dispatch_scheduler_pkg::*;
#(
  parameter int SUPERSCALAR = 2,
  parameter int ROB_DEPTH   = 16,
  parameter int RS_ALU_N    = 4,
  parameter int RS_MUL_N    = 2,
  parameter int RS_MEM_N    = 4,
  parameter int RS_BR_N     = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  dispatch_scheduler_if.slave  bus
);
  sched_state_e                r_state, w_next_state;
  logic                        w_run, w_reload, w_blocked;
  dclass_e                     w_cls;
  logic [CW-1:0]               w_rob_cnt, w_rob_take, w_rob_give;
  logic [3:0][CW-1:0]          w_rs_cnt, w_rs_take, w_rs_give;
  logic [SUPERSCALAR-1:0]      w_pop;
  logic [SUPERSCALAR-1:0][1:0] w_cls_out;

  always_ff @(posedge clk) begin
    if (!rst) r_state <= ST_RUN;
    else      r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_RUN:    if (bus.flush)  w_next_state = ST_FLUSH;
      ST_FLUSH:  if (!bus.flush) w_next_state = ST_REFILL;
      ST_REFILL: w_next_state = ST_RUN;
      default:   w_next_state = ST_RUN;
    endcase
  end

  // A flush request in RUN already counts as leaving RUN: pops are dropped and
  // counters reload so the first RUN cycle after REFILL sees full credits.
  assign w_run    = rst && (r_state == ST_RUN) && !bus.flush;
  assign w_reload = (r_state != ST_RUN) || bus.flush;

  // Once a valid slot fails its credit check, younger slots must not pass it.
  always_comb begin
    w_pop      = '0;
    w_cls_out  = '0;
    w_rob_take = '0;
    w_rs_take  = '0;
    w_blocked  = 1'b0;
    w_cls      = CLS_ALU;
    for (int i = 0; i < SUPERSCALAR; i++) begin
      w_cls = classify(bus.opcode[i], bus.funct7[i]);
      if (w_run && bus.instr_valid_out[i] && !w_blocked) begin
        if ((w_rob_cnt > w_rob_take) && (w_rs_cnt[w_cls] > w_rs_take[w_cls])) begin
          w_pop[i]          = 1'b1;
          w_cls_out[i]      = w_cls;
          w_rob_take        = w_rob_take + CW'(1);
          w_rs_take[w_cls]  = w_rs_take[w_cls] + CW'(1);
        end else begin
          w_blocked = 1'b1;
        end
      end
    end
  end

  assign w_rob_give = CW'(bus.rob_release);
  always_comb begin
    w_rs_give = '0;
    for (int c = 0; c < 4; c++) w_rs_give[c] = CW'(bus.rs_release[c]);
  end

  credit_counter #(.MAX(ROB_DEPTH)) u_rob (
    .clk(clk), .rst(rst), .reload(w_reload),
    .take(w_rob_take), .give(w_rob_give), .count(w_rob_cnt));
  credit_counter #(.MAX(RS_ALU_N)) u_alu (
    .clk(clk), .rst(rst), .reload(w_reload),
    .take(w_rs_take[0]), .give(w_rs_give[0]), .count(w_rs_cnt[0]));
  credit_counter #(.MAX(RS_MUL_N)) u_mul (
    .clk(clk), .rst(rst), .reload(w_reload),
    .take(w_rs_take[1]), .give(w_rs_give[1]), .count(w_rs_cnt[1]));
  credit_counter #(.MAX(RS_MEM_N)) u_mem (
    .clk(clk), .rst(rst), .reload(w_reload),
    .take(w_rs_take[2]), .give(w_rs_give[2]), .count(w_rs_cnt[2]));
  credit_counter #(.MAX(RS_BR_N)) u_br (
    .clk(clk), .rst(rst), .reload(w_reload),
    .take(w_rs_take[3]), .give(w_rs_give[3]), .count(w_rs_cnt[3]));

  assign bus.instr_pop      = w_pop;
  assign bus.dispatch_class = w_cls_out;
  assign bus.stall          = rst && (r_state == ST_RUN) && |(bus.instr_valid_out & ~w_pop);
  assign bus.dbg_state      = r_state;
  assign bus.dbg_rob_credit = w_rob_cnt;
  assign bus.dbg_rs_credit  = w_rs_cnt;

endmodule

// File: tb/tb_dispatch_scheduler.sv
// Directed bench for dispatch_scheduler: a driver pushes the expected per-cycle
// response into a queue and a negedge monitor pops and compares it.
module tb_dispatch_scheduler;
  import dispatch_scheduler_pkg::*;

  localparam int EW = 49;
  localparam logic [6:0] Z      = 7'b0000000;
  localparam logic [6:0] F7_SUB = 7'b0100000;
  localparam logic [6:0] OPC_LUI = 7'b0110111;

  logic clk;
  logic rst;
  logic [EW-1:0] exp_q[$];
  int n_checks;
  int n_fail;
  int cyc;

  dispatch_scheduler_if #(.SUPERSCALAR(2), .ROB_DEPTH(16)) bus ();

  dispatch_scheduler #(
    .SUPERSCALAR(2), .ROB_DEPTH(16),
    .RS_ALU_N(4), .RS_MUL_N(2), .RS_MEM_N(4), .RS_BR_N(2)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    rst = 1'b0;
    bus.instr_valid_out = '0;
    bus.opcode          = '0;
    bus.funct7          = '0;
    bus.rob_release     = '0;
    bus.rs_release      = '0;
    bus.flush           = 1'b0;
  end

  // rs: {br,mem,mul,alu} release, 2 bits each; expected credits are the
  // counter values visible during the cycle (before this cycle's update).
  task automatic step(
    input logic r, input logic [1:0] v,
    input logic [6:0] o0, input logic [6:0] f0,
    input logic [6:0] o1, input logic [6:0] f1,
    input logic [4:0] robr, input logic [7:0] rs, input logic fl,
    input logic [1:0] ep, input logic [3:0] ec, input logic es, input sched_state_e est,
    input logic [7:0] erob, input logic [7:0] ealu, input logic [7:0] emul,
    input logic [7:0] emem, input logic [7:0] ebr);
    @(posedge clk);
    #1;
    rst                 = r;
    bus.instr_valid_out = v;
    bus.opcode[0]       = o0;
    bus.funct7[0]       = f0;
    bus.opcode[1]       = o1;
    bus.funct7[1]       = f1;
    bus.rob_release     = robr;
    bus.rs_release      = rs;
    bus.flush           = fl;
    exp_q.push_back({ep, ec, es, est, erob, ealu, emul, emem, ebr});
  endtask

  // scoreboard monitor
  initial begin
    logic [EW-1:0] e;
    logic [EW-1:0] a;
    cyc = 0;
    forever begin
      @(negedge clk);
      cyc++;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        a = {bus.instr_pop, bus.dispatch_class, bus.stall, bus.dbg_state,
             bus.dbg_rob_credit, bus.dbg_rs_credit[0], bus.dbg_rs_credit[1],
             bus.dbg_rs_credit[2], bus.dbg_rs_credit[3]};
        n_checks++;
        if (a[48:40] !== e[48:40]) begin
          n_fail++;
          $display("FAIL outputs cyc=%0d got pop=%b cls=%b stall=%b state=%0d want pop=%b cls=%b stall=%b state=%0d",
                   cyc, a[48:47], a[46:43], a[42], a[41:40], e[48:47], e[46:43], e[42], e[41:40]);
        end
        n_checks++;
        if (a[39:0] !== e[39:0]) begin
          n_fail++;
          $display("FAIL credits cyc=%0d got rob/alu/mul/mem/br=%0d/%0d/%0d/%0d/%0d want %0d/%0d/%0d/%0d/%0d",
                   cyc, a[39:32], a[31:24], a[23:16], a[15:8], a[7:0],
                   e[39:32], e[31:24], e[23:16], e[15:8], e[7:0]);
        end
      end
    end
  end

  // directed stimulus
  initial begin
    n_checks = 0;
    n_fail   = 0;
    // reset: outputs quiet even with a valid line, credits at maximum
    step(0, 2'b11, OPC_OP, Z, OPC_OP, Z, 0, 8'h00, 0, 2'b00, 4'h0, 0, ST_RUN, 16, 4, 2, 4, 2);
    // dual ALU pop, ALU 4 -> 2
    step(1, 2'b11, OPC_OP, Z, OPC_OP, Z, 0, 8'h00, 0, 2'b11, 4'h0, 0, ST_RUN, 16, 4, 2, 4, 2);
    step(1, 2'b00, OPC_OP, Z, OPC_OP, Z, 0, 8'h00, 0, 2'b00, 4'h0, 0, ST_RUN, 14, 2, 2, 4, 2);
    // two ALU pops plus one ALU release at credit 2 -> 1
    step(1, 2'b11, OPC_OP, Z, OPC_OP, Z, 0, 8'h01, 0, 2'b11, 4'h0, 0, ST_RUN, 14, 2, 2, 4, 2);
    step(1, 2'b00, OPC_OP, Z, OPC_OP, Z, 4, 8'h03, 0, 2'b00, 4'h0, 0, ST_RUN, 12, 1, 2, 4, 2);
    // MUL credit down to 1, then {MUL,MUL}: only slot0 goes
    step(1, 2'b01, OPC_OP, F7_MULDIV, OPC_OP, Z, 0, 8'h00, 0, 2'b01, 4'b0001, 0, ST_RUN, 16, 4, 2, 4, 2);
    step(1, 2'b11, OPC_OP, F7_MULDIV, OPC_OP, F7_MULDIV, 0, 8'h00, 0, 2'b01, 4'b0001, 1, ST_RUN, 15, 4, 1, 4, 2);
    step(1, 2'b10, OPC_OP, Z, OPC_OP, F7_MULDIV, 0, 8'h04, 0, 2'b00, 4'h0, 1, ST_RUN, 14, 4, 0, 4, 2);
    step(1, 2'b10, OPC_OP, Z, OPC_OP, F7_MULDIV, 0, 8'h00, 0, 2'b10, 4'b0100, 0, ST_RUN, 14, 4, 1, 4, 2);
    step(1, 2'b00, OPC_OP, Z, OPC_OP, Z, 3, 8'h08, 0, 2'b00, 4'h0, 0, ST_RUN, 13, 4, 0, 4, 2);
    // drain MEM, then {LW,ADD} must hold in order
    step(1, 2'b11, OPC_LOAD, Z, OPC_LOAD, Z, 0, 8'h00, 0, 2'b11, 4'b1010, 0, ST_RUN, 16, 4, 2, 4, 2);
    step(1, 2'b11, OPC_LOAD, Z, OPC_STORE, Z, 0, 8'h00, 0, 2'b11, 4'b1010, 0, ST_RUN, 14, 4, 2, 2, 2);
    step(1, 2'b11, OPC_LOAD, Z, OPC_OP, Z, 0, 8'h00, 0, 2'b00, 4'h0, 1, ST_RUN, 12, 4, 2, 0, 2);
    step(1, 2'b00, OPC_OP, Z, OPC_OP, Z, 4, 8'h30, 0, 2'b00, 4'h0, 0, ST_RUN, 12, 4, 2, 0, 2);
    step(1, 2'b00, OPC_OP, Z, OPC_OP, Z, 0, 8'h10, 0, 2'b00, 4'h0, 0, ST_RUN, 16, 4, 2, 3, 2);
    // walk ROB credit down to 1 while recycling ALU entries
    for (int k = 0; k < 7; k++) begin
      step(1, 2'b11, OPC_OP, Z, OPC_OP, Z, 0, 8'h02, 0, 2'b11, 4'h0, 0, ST_RUN,
           8'(16 - 2 * k), 4, 2, 4, 2);
    end
    step(1, 2'b01, OPC_OP, Z, OPC_OP, Z, 0, 8'h01, 0, 2'b01, 4'h0, 0, ST_RUN, 2, 4, 2, 4, 2);
    // ROB credit 1 with {ADD,BEQ}; BEQ goes after the ROB release
    step(1, 2'b11, OPC_OP, Z, OPC_BRANCH, Z, 0, 8'h00, 0, 2'b01, 4'h0, 1, ST_RUN, 1, 4, 2, 4, 2);
    step(1, 2'b10, OPC_OP, Z, OPC_BRANCH, Z, 2, 8'h00, 0, 2'b00, 4'h0, 1, ST_RUN, 0, 3, 2, 4, 2);
    step(1, 2'b10, OPC_OP, Z, OPC_BRANCH, Z, 0, 8'h00, 0, 2'b10, 4'b1100, 0, ST_RUN, 2, 3, 2, 4, 2);
    step(1, 2'b00, OPC_OP, Z, OPC_OP, Z, 15, 8'h41, 0, 2'b00, 4'h0, 0, ST_RUN, 1, 3, 2, 4, 1);
    // JAL/JALR are BR; LUI and SUB are ALU
    step(1, 2'b11, OPC_JAL, Z, OPC_JALR, Z, 0, 8'h00, 0, 2'b11, 4'b1111, 0, ST_RUN, 16, 4, 2, 4, 2);
    step(1, 2'b11, OPC_LUI, Z, OPC_OP, F7_SUB, 0, 8'h00, 0, 2'b11, 4'h0, 0, ST_RUN, 14, 4, 2, 4, 0);
    // flush for two cycles: pops suppressed, credits reload, releases ignored
    step(1, 2'b11, OPC_OP, Z, OPC_OP, Z, 1, 8'h00, 1, 2'b00, 4'h0, 1, ST_RUN, 12, 2, 2, 4, 0);
    step(1, 2'b11, OPC_OP, Z, OPC_OP, Z, 0, 8'h00, 1, 2'b00, 4'h0, 0, ST_FLUSH, 16, 4, 2, 4, 2);
    step(1, 2'b11, OPC_OP, Z, OPC_OP, Z, 0, 8'h00, 0, 2'b00, 4'h0, 0, ST_FLUSH, 16, 4, 2, 4, 2);
    step(1, 2'b11, OPC_OP, Z, OPC_OP, Z, 3, 8'h03, 0, 2'b00, 4'h0, 0, ST_REFILL, 16, 4, 2, 4, 2);
    step(1, 2'b11, OPC_OP, Z, OPC_OP, Z, 0, 8'h00, 0, 2'b11, 4'h0, 0, ST_RUN, 16, 4, 2, 4, 2);
    // reset while in FLUSH returns to RUN
    step(1, 2'b00, OPC_OP, Z, OPC_OP, Z, 0, 8'h00, 1, 2'b00, 4'h0, 0, ST_RUN, 14, 2, 2, 4, 2);
    step(0, 2'b11, OPC_OP, Z, OPC_OP, Z, 0, 8'h00, 1, 2'b00, 4'h0, 0, ST_FLUSH, 16, 4, 2, 4, 2);
    step(1, 2'b11, OPC_OP, Z, OPC_OP, Z, 0, 8'h00, 0, 2'b11, 4'h0, 0, ST_RUN, 16, 4, 2, 4, 2);

    @(posedge clk);
    #1;
    bus.instr_valid_out = '0;
    bus.flush           = 1'b0;
    repeat (2) @(posedge clk);
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain got %0d pending entries want 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
